// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the reset/lock handshake of the video-pixel PLL and gates the
//   core reset released to the pixel domain. It pulses the PLL reset and then
//   waits for lock, retrying after a timeout. Lock must then hold for
//   STABLE_CYCLES consecutive cycles before the core is released. A lock loss
//   or a restart request re-runs the whole sequence. The block runs on the
//   free-running 74.25 MHz bridge clock, so it keeps working while the PLL
//   output is dead.
//
// Ports:
//   clk_74a      in   free-running 74.25 MHz clock (also the PLL refclk)
//   reset_n      in   asynchronous active-low reset
//   pll_locked   in   PLL lock, asynchronous to clk_74a (synchronised here)
//   restart_req  in   single-cycle pulse forcing a full re-sequence
//   pll_rst      out  PLL reset, active-high, registered
//   core_reset_n out  downstream core reset, active-low, registered
//   ready        out  high only while in RUN, registered
//   retry_count  out  lock timeouts since reset, saturating
//   loss_count   out  lock losses while in RUN, saturating
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 74250,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned TIMER_W       = 20,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_74a,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             restart_req,
  output logic             pll_rst,
  output logic             core_reset_n,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count
);

  typedef enum logic [1:0] {
    ASSERT_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_e;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         sync_q;
  logic               locked_s;
  logic               retry_inc, loss_inc;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               pll_rst_q, pll_rst_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               ready_q, ready_d;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // State, timer, counter and output registers.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ASSERT_RST;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_rst_q    <= pll_rst_d;
      core_rst_n_q <= core_rst_n_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state logic. restart_req overrides every transition and never
  // touches the counters.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (restart_req) begin
      state_d = ASSERT_RST;
      timer_d = '0;
    end else begin
      case (state_q)
        ASSERT_RST: begin
          if (timer_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock wins over a timeout landing in the same cycle.
          if (locked_s) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d   = ASSERT_RST;
            timer_d   = '0;
            retry_inc = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        STABLE: begin
          // A dropout restarts both the stability count and the lock
          // timeout budget, without re-pulsing the PLL.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d  = ASSERT_RST;
            timer_d  = '0;
            loss_inc = 1'b1;
          end
        end
        default: begin
          state_d = ASSERT_RST;
          timer_d = '0;
        end
      endcase
    end
  end

  // Saturating status counters.
  always_comb begin
    retry_d = retry_q;
    loss_d  = loss_q;
    if (retry_inc && (retry_q != '1)) begin
      retry_d = retry_q + 1'b1;
    end
    if (loss_inc && (loss_q != '1)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  // Outputs decode the next state so that the registered outputs change on
  // the same edge as the state they belong to.
  always_comb begin
    pll_rst_d    = 1'b0;
    core_rst_n_d = 1'b0;
    ready_d      = 1'b0;
    case (state_d)
      ASSERT_RST: pll_rst_d = 1'b1;
      RUN: begin
        core_rst_n_d = 1'b1;
        ready_d      = 1'b1;
      end
      default: begin
        pll_rst_d    = 1'b0;
        core_rst_n_d = 1'b0;
        ready_d      = 1'b0;
      end
    endcase
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_rst_n_q;
  assign ready        = ready_q;
  assign retry_count  = retry_q;
  assign loss_count   = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed self-checking bench for pll_reset_sequencer with RST_CYCLES=16,
//   LOCK_TIMEOUT=50, STABLE_CYCLES=1024, CNT_W=2. Inputs change 1 ns after a
//   rising edge; outputs are sampled at the same point.
module tb_pll_reset_sequencer;

  localparam int CNT_W = 2;

  logic             clk_74a = 1'b0;
  logic             reset_n;
  logic             pll_locked;
  logic             restart_req;
  logic             pll_rst;
  logic             core_reset_n;
  logic             ready;
  logic [CNT_W-1:0] retry_count;
  logic [CNT_W-1:0] loss_count;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .RST_CYCLES   (16),
    .LOCK_TIMEOUT (50),
    .STABLE_CYCLES(1024),
    .TIMER_W      (20),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .restart_req (restart_req),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .ready       (ready),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  always #5 clk_74a = ~clk_74a;

  typedef struct {
    string      name;
    logic       locked;
    logic       restart;
    int         cycles;
    logic       exp_pll_rst;
    logic       exp_core_n;
    logic       exp_ready;
    logic [1:0] exp_retry;
    logic [1:0] exp_loss;
  } vec_t;

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return core_reset_n;
      default: return ready;
    endcase
  endfunction

  // Counts rising edges until the selected output reads val, bounded by limit.
  task automatic count_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((get_out(sel) !== val) && (n < limit));
  endtask

  task automatic check_all(input string name, input logic p, input logic c, input logic r,
                           input logic [1:0] rc, input logic [1:0] lc);
    check({name, ".pll_rst"}, 32'(pll_rst), 32'(p));
    check({name, ".core_reset_n"}, 32'(core_reset_n), 32'(c));
    check({name, ".ready"}, 32'(ready), 32'(r));
    check({name, ".retry_count"}, 32'(retry_count), 32'(rc));
    check({name, ".loss_count"}, 32'(loss_count), 32'(lc));
  endtask

  initial begin
    vec_t vecs[$];
    int   n;
    logic saw_rst;

    // Timeline after the restart in the combined restart/loss test:
    // ASSERT_RST 16 cycles then WAIT_LOCK 50 cycles -> one retry every 66.
    vecs.push_back('{"to_t10",  1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1});
    vecs.push_back('{"to_t20",  1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1});
    vecs.push_back('{"to_t65",  1'b0, 1'b0, 45, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1});
    vecs.push_back('{"to_t66",  1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 2'd1, 2'd1});
    vecs.push_back('{"to_t82",  1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1});
    vecs.push_back('{"to_t132", 1'b0, 1'b0, 50, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1});
    vecs.push_back('{"to_t198", 1'b0, 1'b0, 66, 1'b1, 1'b0, 1'b0, 2'd3, 2'd1});
    vecs.push_back('{"to_t264", 1'b0, 1'b0, 66, 1'b1, 1'b0, 1'b0, 2'd3, 2'd1});
    vecs.push_back('{"to_t281", 1'b0, 1'b0, 17, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1});
    vecs.push_back('{"to_t330", 1'b0, 1'b0, 49, 1'b1, 1'b0, 1'b0, 2'd3, 2'd1});
    vecs.push_back('{"relock",  1'b1, 1'b0, 1100, 1'b0, 1'b1, 1'b1, 2'd3, 2'd1});

    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    restart_req = 1'b0;
    tick();
    tick();
    check_all("reset", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);

    // Normal bring-up.
    reset_n = 1'b1;
    count_until(0, 1'b0, 100, n);
    check("pll_rst_width", 32'(n), 32'd16);
    repeat (30) tick();
    pll_locked = 1'b1;
    count_until(1, 1'b1, 1200, n);
    check("release_latency", 32'(n), 32'd1027);
    check_all("run", 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    count_until(1, 1'b0, 20, n);
    check("loss_latency", 32'(n), 32'd3);
    check_all("loss", 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
    count_until(0, 1'b0, 40, n);
    check("loss_pll_rst_width", 32'(n), 32'd16);
    pll_locked = 1'b1;
    count_until(1, 1'b1, 1200, n);
    check("relock_latency", 32'(n), 32'd1027);
    check_all("relock", 1'b0, 1'b1, 1'b1, 2'd0, 2'd1);

    // restart_req in RUN, then a lock glitch during STABLE.
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    check_all("restart", 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
    count_until(0, 1'b0, 40, n);
    check("restart_pll_rst_width", 32'(n), 32'd16);
    repeat (500) tick();
    pll_locked = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    saw_rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (pll_rst !== 1'b0) saw_rst = 1'b1;
    end while ((core_reset_n !== 1'b1) && (n < 1200));
    check("glitch_release_latency", 32'(n), 32'd1027);
    check("glitch_no_pll_rst", 32'(saw_rst), 32'd0);
    check("glitch_retry", 32'(retry_count), 32'd0);

    // restart_req coincident with lock loss: restart wins, no loss counted.
    pll_locked = 1'b0;
    tick();
    tick();
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    check_all("restart_vs_loss", 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);

    // Timeout / retry saturation table, ending with a relock to RUN.
    foreach (vecs[i]) begin
      pll_locked  = vecs[i].locked;
      restart_req = vecs[i].restart;
      repeat (vecs[i].cycles) tick();
      check_all(vecs[i].name, vecs[i].exp_pll_rst, vecs[i].exp_core_n,
                vecs[i].exp_ready, vecs[i].exp_retry, vecs[i].exp_loss);
    end

    // Async reset in WAIT_LOCK with non-zero counters.
    pll_locked = 1'b0;
    repeat (3) tick();
    check("loss_count_2", 32'(loss_count), 32'd2);
    repeat (16) tick();
    check("wait_lock_pll_rst", 32'(pll_rst), 32'd0);
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    #5;
    reset_n = 1'b1;
    count_until(0, 1'b0, 100, n);
    check("post_reset_pll_rst_width", 32'(n), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sequences the reset and lock handshake of the video-pixel PLL (74.25 MHz in, 23.75 MHz out) and gates the core reset released to the pixel domain. Pulses the PLL reset and waits for lock, with a timeout and retry. Requires lock to stay stable before releasing the core, and re-runs the sequence on lock loss or on request. Runs on the free-running 74.25 MHz bridge clock, so it operates while the PLL output is dead.

Parameters:
RST_CYCLES, 16, clk_74a cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 74250, cycles allowed in WAIT_LOCK before retry (1 ms)
STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (>=1)
TIMER_W, 20, internal timer width; every cycle parameter < 2^TIMER_W
CNT_W, 8, width of status counters

Ports:
clk_74a  in  1  74.25 MHz free-running clock, also the PLL refclk
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked output, asynchronous to clk_74a
restart_req  in  1  single-cycle pulse; forces a full re-sequence
pll_rst  out  1  drives PLL rst, active-high
core_reset_n  out  1  active-low reset for the downstream core, registered in clk_74a; consumers re-synchronise it into their own domain
ready  out  1  high only in RUN
retry_count  out  CNT_W  lock timeouts since reset, saturating
loss_count  out  CNT_W  lock losses while in RUN, saturating

Behaviour:
- Reset (reset_n low, async): state=ASSERT_RST, timer=0, pll_rst=1, core_reset_n=0, ready=0, counters=0, sync flops=0.
- pll_locked passes through a 2-flop synchroniser (locked_s). All decisions use locked_s: 2-cycle sync latency.
- All outputs are registered, with no combinational path from inputs.
- States:
  - ASSERT_RST: pll_rst=1, core_reset_n=0. Timer counts 0..RST_CYCLES-1. At RST_CYCLES-1: timer=0, go to WAIT_LOCK. pll_rst is therefore high exactly RST_CYCLES cycles.
  - WAIT_LOCK: pll_rst=0. If locked_s=1: go to STABLE, timer=0. Otherwise, when the timer reaches LOCK_TIMEOUT-1: retry_count++ (saturating at 2^CNT_W-1), go to ASSERT_RST. Lock has priority over timeout in the same cycle.
  - STABLE: pll_rst=0, core_reset_n=0. If locked_s=0: timer=0, return to WAIT_LOCK. The remaining timeout budget restarts, and retry_count is unchanged. If locked_s=1 for STABLE_CYCLES consecutive cycles: go to RUN.
  - RUN: core_reset_n=1, ready=1, registered on the same edge the state is entered. If locked_s=0: loss_count++ (saturating), go to ASSERT_RST. core_reset_n=0 and ready=0 take effect on that edge.
- restart_req has priority over every other transition in every state. It forces ASSERT_RST with timer=0 and changes no counter. If it arrives during ASSERT_RST, pll_rst is extended to a fresh RST_CYCLES.
- In RUN, restart_req and lock loss in the same cycle: restart wins, loss_count is not incremented.
- Counters never wrap. They clear only on reset_n.
- Asserting reset_n mid-sequence aborts immediately to the reset values. Release of reset_n starts a fresh ASSERT_RST.
- Timer is cleared on every state change and does not run in RUN.
- Latency from pll_locked rising in WAIT_LOCK to core_reset_n=1: 2 (sync) + 1 (to STABLE) + STABLE_CYCLES cycles.

Test Plan:
- Normal bring-up, RST_CYCLES=16, STABLE_CYCLES=1024: release reset_n, raise pll_locked 100 cycles after pll_rst falls -> pll_rst high exactly 16 cycles; core_reset_n and ready rise 1027 cycles after pll_locked rises; both counters stay 0.
- Timeout, LOCK_TIMEOUT=50: pll_locked held 0 -> pll_rst re-pulses every 66 cycles; retry_count increments 1,2,3…; with CNT_W=2, retry_count saturates at 3 and pulsing continues.
- Glitch during STABLE: pll_locked drops for 5 cycles at STABLE cycle 500, then recovers -> no pll_rst pulse; release occurs a full 1024 stable cycles after recovery; retry_count stays 0.
- Lock loss in RUN: drop pll_locked -> core_reset_n and ready go 0 exactly 3 cycles later; pll_rst pulses 16 cycles; loss_count=1; relock releases again.
- restart_req: pulse it in RUN -> ASSERT_RST next edge; loss_count and retry_count unchanged. Pulse it together with lock loss -> loss_count unchanged.
- Async reset mid-WAIT_LOCK: assert reset_n between clock edges -> pll_rst=1 and core_reset_n=0 immediately, without waiting for an edge; counters read 0.
